// File: rtl/capture_pkg.sv
// Shared types and widths for the capture writer and its word FIFO.
package capture_pkg;

  localparam int DDR_WORD_W = 128;
  localparam int DDR_ADX_W  = 27;
  localparam int FIFO_W     = DDR_ADX_W + DDR_WORD_W;

  // Encoding is visible on cap_state: 0 IDLE, 1 ARMED, 2 POST, 3 DONE.
  typedef enum logic [1:0] {
    CAP_IDLE  = 2'd0,
    CAP_ARMED = 2'd1,
    CAP_POST  = 2'd2,
    CAP_DONE  = 2'd3
  } cap_state_t;

endpackage

// File: rtl/capture_word_fifo.sv
// Synchronous word FIFO holding {address, data} entries for the DDR write port.
// Push while full and pop while empty are ignored; flush empties it in one edge.
module capture_word_fifo import capture_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int W     = FIFO_W,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush behaves like a local reset.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage array; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/capture_writer.sv
// Packs logic-analyser samples into 128-bit words, writes them round-robin into
// a DDR capture region and runs the arm / trigger / post-trigger sequence.
//
// Write handshake: write_req = FIFO not empty AND write_allowed. Whenever
// write_req is high, wr_adx_out/wr_data_out (the FIFO head) are consumed at
// that clock edge and the head is popped; there is no other acceptance signal.
module capture_writer import capture_pkg::*; #(
  parameter int                   SAMPLE_W    = 16,
  parameter logic [DDR_ADX_W-1:0] BASE_ADX    = 27'h0,
  parameter int                   DEPTH_WORDS = 1 << 20,
  parameter int                   ADX_STEP    = 8,
  parameter int                   FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [SAMPLE_W-1:0]   sample_in,
  input  logic                  sample_valid,
  input  logic                  trigger,
  input  logic [23:0]           post_words,
  output logic [DDR_ADX_W-1:0]  wr_adx_out,
  output logic [DDR_WORD_W-1:0] wr_data_out,
  output logic                  write_req,
  input  logic                  write_allowed,
  output logic [1:0]            cap_state,
  output logic [DDR_ADX_W-1:0]  trig_adx,
  output logic                  wrapped,
  output logic                  overflow,
  output logic                  done
);

  localparam int SPW = DDR_WORD_W / SAMPLE_W;
  localparam int LW  = (SPW > 1) ? $clog2(SPW) : 1;
  localparam int CW  = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;
  localparam longint END_L = longint'(BASE_ADX) + longint'(DEPTH_WORDS) * longint'(ADX_STEP);
  localparam logic [DDR_ADX_W-1:0] END_ADX  = DDR_ADX_W'(END_L);
  localparam logic [DDR_ADX_W-1:0] STEP_ADX = DDR_ADX_W'(ADX_STEP);

  cap_state_t state, state_nxt;

  logic [LW-1:0]         lane;
  logic [DDR_WORD_W-1:0] pack_word;
  logic [DDR_WORD_W-1:0] pack_full;
  logic                  pend_valid;
  logic [DDR_WORD_W-1:0] pend_data;
  logic [DDR_ADX_W-1:0]  next_adx;
  logic [DDR_ADX_W-1:0]  adx_stepped;
  logic [DDR_ADX_W-1:0]  adx_adv;
  logic [DDR_ADX_W-1:0]  adx_after;
  logic                  wrap_hit;
  logic [23:0]           post_cnt;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [FIFO_W-1:0]     fifo_head;

  logic push_ok, drop, intake, take_trig, arm_go, post_end;

  // The word completed on the previous edge goes out now unless the FIFO is
  // already full; a same-cycle pop does not make room for it.
  assign push_ok     = pend_valid && !fifo_full;
  assign drop        = pend_valid && (fifo_count == CW'(FIFO_DEPTH));
  assign adx_stepped = next_adx + STEP_ADX;
  assign wrap_hit    = (adx_stepped == END_ADX);
  assign adx_adv     = wrap_hit ? BASE_ADX : adx_stepped;
  // Address the word currently being packed will be enqueued with.
  assign adx_after   = push_ok ? adx_adv : next_adx;

  assign post_end  = (state == CAP_POST) && (post_cnt == '0);
  assign intake    = sample_valid && ((state == CAP_ARMED) || ((state == CAP_POST) && (post_cnt != '0)));
  assign take_trig = (state == CAP_ARMED) && trigger && sample_valid;
  assign arm_go    = arm && !abort && ((state == CAP_IDLE) || (state == CAP_DONE));

  assign write_req   = !fifo_empty && write_allowed;
  assign wr_adx_out  = fifo_empty ? '0 : fifo_head[FIFO_W-1 -: DDR_ADX_W];
  assign wr_data_out = fifo_empty ? '0 : fifo_head[DDR_WORD_W-1:0];
  assign cap_state   = state;
  assign done        = (state == CAP_DONE);

  // Current word with the incoming sample dropped into its lane.
  always_comb begin
    pack_full = pack_word;
    pack_full[int'(lane) * SAMPLE_W +: SAMPLE_W] = sample_in;
  end

  // Capture state register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= CAP_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_nxt = state;
    case (state)
      CAP_IDLE:  if (arm) state_nxt = CAP_ARMED;
      CAP_ARMED: if (trigger && sample_valid) state_nxt = CAP_POST;
      CAP_POST:  if ((post_cnt == '0) && fifo_empty && !pend_valid && !write_req) state_nxt = CAP_DONE;
      CAP_DONE:  if (arm) state_nxt = CAP_ARMED;
      default:   state_nxt = CAP_IDLE;
    endcase
    if (abort) state_nxt = CAP_IDLE;
  end

  // Packer, address generator, post counter and sticky status flags.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lane       <= '0;
      pack_word  <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      next_adx   <= BASE_ADX;
      post_cnt   <= '0;
      trig_adx   <= '0;
      wrapped    <= 1'b0;
      overflow   <= 1'b0;
    end else if (abort) begin
      lane       <= '0;
      pack_word  <= '0;
      pend_valid <= 1'b0;
      post_cnt   <= '0;
    end else if (arm_go) begin
      lane       <= '0;
      pack_word  <= '0;
      pend_valid <= 1'b0;
      next_adx   <= BASE_ADX;
      post_cnt   <= '0;
      wrapped    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      pend_valid <= 1'b0;
      if (push_ok) begin
        next_adx <= adx_adv;
        if (wrap_hit) wrapped <= 1'b1;
        if ((state == CAP_POST) && (post_cnt != '0)) post_cnt <= post_cnt - 24'd1;
      end
      if (drop) overflow <= 1'b1;
      if (post_end) begin
        // Capture finished: any partially packed word is thrown away.
        lane      <= '0;
        pack_word <= '0;
      end else if (intake) begin
        pack_word <= pack_full;
        if (lane == LW'(SPW - 1)) begin
          lane       <= '0;
          pend_valid <= 1'b1;
          pend_data  <= pack_full;
        end else begin
          lane <= lane + 1'b1;
        end
      end
      if (take_trig) begin
        trig_adx <= adx_after;
        post_cnt <= (post_words == '0) ? 24'd1 : post_words;
      end
    end
  end

  capture_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (FIFO_W),
    .AW    (CW - 1)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (abort),
    .push      (push_ok),
    .push_data ({next_adx, pend_data}),
    .pop       (write_req),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_capture_writer.sv
// Self-checking bench for capture_writer: directed capture scenarios plus
// randomized traffic, all compared cycle by cycle against a queue-based model.
module tb_capture_writer;

  localparam int SPW  = 8;
  localparam int FD   = 4;
  localparam int DW   = 4;
  localparam int STEP = 8;
  localparam logic [26:0] BASE = 27'h0;

  logic         clk = 1'b0;
  logic         resetn, arm, abort, sample_valid, trigger, write_allowed;
  logic [15:0]  sample_in;
  logic [23:0]  post_words;
  logic [26:0]  wr_adx_out, trig_adx;
  logic [127:0] wr_data_out;
  logic         write_req, wrapped, overflow, done;
  logic [1:0]   cap_state;

  int n_checks = 0;
  int n_err    = 0;

  // model of the capture as seen from outside
  logic [154:0] m_fifo[$];
  logic [154:0] wr_log[$];
  int           m_state, m_lanes, m_left;
  logic [127:0] m_part, m_pend_data;
  bit           m_pend, m_wrapped, m_ovf;
  logic [26:0]  m_next, m_trig;

  capture_writer #(
    .SAMPLE_W    (16),
    .BASE_ADX    (BASE),
    .DEPTH_WORDS (DW),
    .ADX_STEP    (STEP),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .arm           (arm),
    .abort         (abort),
    .sample_in     (sample_in),
    .sample_valid  (sample_valid),
    .trigger       (trigger),
    .post_words    (post_words),
    .wr_adx_out    (wr_adx_out),
    .wr_data_out   (wr_data_out),
    .write_req     (write_req),
    .write_allowed (write_allowed),
    .cap_state     (cap_state),
    .trig_adx      (trig_adx),
    .wrapped       (wrapped),
    .overflow      (overflow),
    .done          (done)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [154:0] got, input logic [154:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [154:0] log_at(input int i);
    if (i < wr_log.size()) return wr_log[i];
    return '1;
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_state = 0; m_lanes = 0; m_left = 0;
    m_part = '0; m_pend = 0; m_pend_data = '0;
    m_next = BASE; m_trig = '0; m_wrapped = 0; m_ovf = 0;
  endtask

  task automatic compare_outputs();
    logic [154:0] hd;
    hd = (m_fifo.size() > 0) ? m_fifo[0] : '0;
    check("cap_state", cap_state, m_state);
    check("done", done, (m_state == 3));
    check("write_req", write_req, (m_fifo.size() > 0) && write_allowed);
    check("wr_adx_out", wr_adx_out, hd[154:128]);
    check("wr_data_out", wr_data_out, hd[127:0]);
    check("trig_adx", trig_adx, m_trig);
    check("wrapped", wrapped, m_wrapped);
    check("overflow", overflow, m_ovf);
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int   st, left_b;
    bit   pend_b, was_empty, pop, full_now, ending, accept;
    logic [26:0] n;
    if (!resetn) begin
      model_reset();
      return;
    end
    st = m_state; left_b = m_left; pend_b = m_pend;
    was_empty = (m_fifo.size() == 0);
    pop = !was_empty && write_allowed;
    full_now = (m_fifo.size() == FD);
    if (abort) begin
      m_state = 0; m_fifo.delete(); m_lanes = 0; m_part = '0; m_pend = 0; m_left = 0;
      return;
    end
    if (arm && (st == 0 || st == 3)) begin
      m_state = 1; m_lanes = 0; m_part = '0; m_pend = 0; m_left = 0;
      m_next = BASE; m_wrapped = 0; m_ovf = 0;
      return;
    end
    if (pop) void'(m_fifo.pop_front());
    if (pend_b) begin
      if (full_now) m_ovf = 1;
      else begin
        m_fifo.push_back({m_next, m_pend_data});
        n = m_next + 27'(STEP);
        if (n == BASE + 27'(DW * STEP)) begin
          n = BASE;
          m_wrapped = 1;
        end
        m_next = n;
        if (st == 2 && m_left > 0) m_left--;
      end
    end
    m_pend = 0;
    ending = (st == 2) && (left_b == 0);
    accept = sample_valid && ((st == 1) || (st == 2 && left_b > 0));
    if (ending) begin
      m_lanes = 0; m_part = '0;
    end else if (accept) begin
      m_part[m_lanes * 16 +: 16] = sample_in;
      m_lanes++;
      if (m_lanes == SPW) begin
        m_pend = 1; m_pend_data = m_part; m_lanes = 0;
      end
    end
    if (st == 1 && trigger && sample_valid) begin
      m_trig = m_next;
      m_left = (post_words == 0) ? 1 : int'(post_words);
      m_state = 2;
    end else if (ending && was_empty && !pend_b) begin
      m_state = 3;
    end
  endtask

  // driver tasks; inputs change on the falling edge
  task automatic step();
    #1;
    compare_outputs();
    if (write_req) wr_log.push_back({wr_adx_out, wr_data_out});
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic feed(input int n, input int first, input int trig_at);
    for (int i = 0; i < n; i++) begin
      sample_valid = 1'b1;
      sample_in = 16'(first + i);
      trigger = (i == trig_at);
      step();
    end
    sample_valid = 1'b0;
    trigger = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; step(); arm = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  task automatic clear_inputs();
    arm = 0; abort = 0; sample_valid = 0; trigger = 0; sample_in = '0; resetn = 1;
  endtask

  initial begin
    logic [154:0] w;
    model_reset();
    resetn = 0; arm = 0; abort = 0; sample_valid = 0; trigger = 0;
    sample_in = '0; post_words = '0; write_allowed = 1;
    @(negedge clk);
    idle(3);
    check("rst_cap_state", cap_state, 0);
    check("rst_write_req", write_req, 0);
    check("rst_wr_adx", wr_adx_out, 0);
    resetn = 1;

    // arm and pack two words without a trigger
    wr_log.delete();
    pulse_arm();
    feed(16, 1, -1);
    idle(4);
    check("p1_nwrites", wr_log.size(), 2);
    w = log_at(0);
    check("p1_adx0", w[154:128], 27'h0);
    check("p1_data0", w[127:0], 128'h00080007000600050004000300020001);
    w = log_at(1);
    check("p1_adx1", w[154:128], 27'h8);
    check("p1_data1", w[127:0], 128'h0010000f000e000d000c000b000a0009);
    check("p1_state", cap_state, 1);

    // trigger on the third sample, two post words
    pulse_abort();
    pulse_arm();
    wr_log.delete();
    post_words = 24'd2;
    feed(16, 1, 2);
    feed(8, 100, -1);
    idle(4);
    check("p2_trig_adx", trig_adx, 27'h0);
    check("p2_state", cap_state, 3);
    check("p2_done", done, 1);
    check("p2_nwrites", wr_log.size(), 2);
    w = log_at(1);
    check("p2_adx1", w[154:128], 27'h8);

    // wrap through a four-word region
    wr_log.delete();
    pulse_arm();
    feed(48, 1, -1);
    idle(4);
    check("p3_nwrites", wr_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      w = log_at(i);
      check("p3_adx", w[154:128], 27'((i % 4) * 8));
    end
    check("p3_wrapped", wrapped, 1);

    // back-pressure: six words offered, four fit
    pulse_abort();
    pulse_arm();
    wr_log.delete();
    write_allowed = 0;
    feed(48, 1, -1);
    idle(2);
    check("p4_overflow", overflow, 1);
    check("p4_req_held", write_req, 0);
    write_allowed = 1;
    idle(8);
    check("p4_nwrites", wr_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      w = log_at(i);
      check("p4_adx", w[154:128], 27'(i * 8));
      check("p4_lane0", w[15:0], 16'(1 + 8 * i));
    end

    // abort in POST with two words queued
    pulse_abort();
    pulse_arm();
    write_allowed = 0;
    post_words = 24'd5;
    feed(16, 1, 0);
    idle(2);
    check("p5_state_post", cap_state, 2);
    wr_log.delete();
    pulse_abort();
    check("p5_state_idle", cap_state, 0);
    check("p5_done", done, 0);
    write_allowed = 1;
    idle(4);
    check("p5_nwrites", wr_log.size(), 0);
    pulse_arm();
    feed(8, 50, -1);
    idle(4);
    check("p5_rearm_n", wr_log.size(), 1);
    w = log_at(0);
    check("p5_rearm_adx", w[154:128], BASE);

    // post_words = 0 behaves as one word, then arm+abort together in DONE
    wr_log.delete();
    post_words = 24'd0;
    feed(16, 200, 1);
    idle(6);
    check("p6_trig_adx", trig_adx, 27'h8);
    check("p6_state", cap_state, 3);
    check("p6_nwrites", wr_log.size(), 1);
    w = log_at(0);
    check("p6_adx", w[154:128], 27'h8);
    arm = 1; abort = 1; step(); arm = 0; abort = 0;
    check("p6_abort_wins", cap_state, 0);

    // randomized traffic, including stray arms, aborts and resets
    for (int r = 0; r < 6; r++) begin
      pulse_abort();
      pulse_arm();
      for (int c = 0; c < 250; c++) begin
        sample_valid  = ($urandom_range(0, 99) < 75);
        sample_in     = 16'($urandom);
        trigger       = ($urandom_range(0, 99) < 4);
        post_words    = ($urandom_range(0, 9) == 0) ? 24'd12 : 24'($urandom_range(0, 3));
        write_allowed = ($urandom_range(0, 99) < (30 + r * 12));
        arm           = ($urandom_range(0, 99) < 3);
        abort         = ($urandom_range(0, 199) == 0);
        resetn        = ($urandom_range(0, 299) != 0);
        step();
      end
      clear_inputs();
      write_allowed = 1;
      idle(8);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
